// File: rtl/anchor_ebi_wr_rx.sv
// anchor_ebi_wr_rx: EBI host write receiver with strobe qualification and FWFT output FIFO
module anchor_ebi_wr_rx #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int SYNC_FF    = 2,
    parameter int MIN_LOW    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ebi_ncs,
    input  logic                          ebi_nwe,
    input  logic [ADDR_W-1:0]             ebi_addr,
    input  logic [DATA_W-1:0]             ebi_data,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [DATA_W-1:0]             wr_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovf,
    input  logic                          ovf_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    typedef enum logic [1:0] {IDLE, LOW, COMMIT} state_t;
    logic [SYNC_FF-1:0]             ncs_q, ncs_d, nwe_q, nwe_d, primed_q, primed_d;
    logic [SYNC_FF-1:0][ADDR_W-1:0] apipe_q, apipe_d;
    logic [SYNC_FF-1:0][DATA_W-1:0] dpipe_q, dpipe_d;
    logic                           strobe_s, armed_q, armed_d;
    state_t                         state_q, state_d;
    logic [3:0]                     cnt_q, cnt_d;
    logic [ADDR_W-1:0]              word_addr_q, word_addr_d;
    logic [DATA_W-1:0]              word_data_q, word_data_d;
    logic [ADDR_W-1:0]              mem_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0]              mem_data_q [FIFO_DEPTH];
    logic [AW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]                  level_q, level_d;
    logic                           ovf_q, ovf_d, push_req, push, pop, full;

    assign strobe_s   = ~ncs_q[SYNC_FF-1] & ~nwe_q[SYNC_FF-1];
    assign wr_valid   = level_q != '0;
    assign fifo_level = level_q;
    assign ovf        = ovf_q;
    assign wr_addr    = wr_valid ? mem_addr_q[rd_ptr_q] : '0;
    assign wr_data    = wr_valid ? mem_data_q[rd_ptr_q] : '0;

    // Strobe synchronizers, equal-depth addr/data delay line, and arming after reset:
    // a strobe is only accepted once the chain holds real pin samples showing it inactive.
    always_comb begin
        ncs_d    = {ncs_q[SYNC_FF-2:0], ebi_ncs};
        nwe_d    = {nwe_q[SYNC_FF-2:0], ebi_nwe};
        primed_d = {primed_q[SYNC_FF-2:0], 1'b1};
        apipe_d  = {apipe_q[SYNC_FF-2:0], ebi_addr};
        dpipe_d  = {dpipe_q[SYNC_FF-2:0], ebi_data};
        armed_d  = armed_q | (primed_q[SYNC_FF-1] & ~strobe_s);
    end

    // Strobe qualification FSM: measure low width, latch the word, commit or discard
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_addr_d = word_addr_q;
        word_data_d = word_data_q;
        push_req    = 1'b0;
        case (state_q)
            IDLE: if (armed_q && strobe_s) begin
                state_d     = LOW;
                cnt_d       = 4'd1;
                word_addr_d = apipe_q[SYNC_FF-1];
                word_data_d = dpipe_q[SYNC_FF-1];
            end
            LOW: if (strobe_s) begin
                cnt_d       = (cnt_q < 4'(MIN_LOW)) ? cnt_q + 4'd1 : cnt_q;
                word_addr_d = apipe_q[SYNC_FF-1];
                word_data_d = dpipe_q[SYNC_FF-1];
            end else begin
                state_d = (cnt_q >= 4'(MIN_LOW)) ? COMMIT : IDLE;
                cnt_d   = '0;
            end
            COMMIT: begin
                push_req = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointer/level bookkeeping; a full FIFO still accepts a push when popping
    always_comb begin
        full     = level_q == LW'(FIFO_DEPTH);
        pop      = wr_valid & wr_ready;
        push     = push_req & (~full | pop);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);
        ovf_d    = (push_req & full & ~pop) | (ovf_q & ~ovf_clr);
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs_q       <= '1;
            nwe_q       <= '1;
            primed_q    <= '0;
            apipe_q     <= '0;
            dpipe_q     <= '0;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            word_addr_q <= '0;
            word_data_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            ncs_q       <= ncs_d;
            nwe_q       <= nwe_d;
            primed_q    <= primed_d;
            apipe_q     <= apipe_d;
            dpipe_q     <= dpipe_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_addr_q <= word_addr_d;
            word_data_q <= word_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
        end
    end

    // FIFO storage; outputs are masked while empty so no reset is needed here
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[wr_ptr_q] <= word_addr_q;
            mem_data_q[wr_ptr_q] <= word_data_q;
        end
    end
endmodule

// File: tb/tb_anchor_ebi_wr_rx.sv
// tb_anchor_ebi_wr_rx: directed self-checking bench for the EBI write receiver
module tb_anchor_ebi_wr_rx;
    logic        clk = 1'b0;
    logic        rst_n, ebi_ncs, ebi_nwe, wr_ready, ovf_clr;
    logic [7:0]  ebi_addr;
    logic [15:0] ebi_data;
    logic        wr_valid, ovf;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  fifo_level;
    int          checks = 0;
    int          errors = 0;

    anchor_ebi_wr_rx dut (
        .clk(clk), .rst_n(rst_n), .ebi_ncs(ebi_ncs), .ebi_nwe(ebi_nwe),
        .ebi_addr(ebi_addr), .ebi_data(ebi_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .fifo_level(fifo_level), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Strobe pins low for n sampling edges, then release; pins change afterwards
    task automatic ebi_write(input logic [7:0] a, input logic [15:0] d, input int n);
        @(negedge clk);
        ebi_addr = a; ebi_data = d; ebi_ncs = 1'b0; ebi_nwe = 1'b0;
        repeat (n) @(negedge clk);
        ebi_nwe = 1'b1; ebi_ncs = 1'b1; ebi_addr = ~a; ebi_data = ~d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ebi_ncs = 1'b1; ebi_nwe = 1'b1; ebi_addr = 8'h00; ebi_data = 16'h0000;
        wr_ready = 1'b0; ovf_clr = 1'b0;
        #12;
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", wr_valid); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", ovf); end
        checks++; if (wr_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %0h exp 0", wr_addr); end
        checks++; if (wr_data !== 16'h0000) begin errors++; $display("FAIL reset_data got %0h exp 0", wr_data); end
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_write();
        wr_ready = 1'b1;
        ebi_write(8'h5A, 16'hBEEF, 4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (wr_valid !== (i == 3)) begin errors++; $display("FAIL single_valid_e%0d got %0b exp %0b", i, wr_valid, i == 3); end
            if (i == 3) begin
                checks++; if (wr_addr !== 8'h5A) begin errors++; $display("FAIL single_addr got %0h exp 5a", wr_addr); end
                checks++; if (wr_data !== 16'hBEEF) begin errors++; $display("FAIL single_data got %0h exp beef", wr_data); end
            end
        end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL single_level got %0d exp 0", fifo_level); end
        @(negedge clk); wr_ready = 1'b0;
    endtask

    task automatic test_min_width();
        wr_ready = 1'b0;
        ebi_write(8'h21, 16'h0202, 2);
        repeat (6) @(negedge clk);
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL minw_level got %0d exp 1", fifo_level); end
        checks++; if (wr_addr !== 8'h21) begin errors++; $display("FAIL minw_addr got %0h exp 21", wr_addr); end
        checks++; if (wr_data !== 16'h0202) begin errors++; $display("FAIL minw_data got %0h exp 0202", wr_data); end
        wr_ready = 1'b1;
        @(negedge clk); wr_ready = 1'b0;
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL minw_pop_level got %0d exp 0", fifo_level); end
    endtask

    task automatic test_glitch();
        wr_ready = 1'b0;
        ebi_write(8'h99, 16'h9999, 1);
        repeat (8) @(negedge clk);
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid got %0b exp 0", wr_valid); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL glitch_level got %0d exp 0", fifo_level); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL glitch_ovf got %0b exp 0", ovf); end
        checks++; if (dut.state_q !== 2'd0) begin errors++; $display("FAIL glitch_state got %0d exp 0", dut.state_q); end
    endtask

    task automatic test_overflow();
        wr_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            ebi_write(8'h10 + 8'(i), 16'(i), 3);
            repeat (6) @(negedge clk);
            if (i == 4) begin
                checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level4 got %0d exp 4", fifo_level); end
                checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_not_yet got %0b exp 0", ovf); end
            end
        end
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level_after5 got %0d exp 4", fifo_level); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b exp 1", ovf); end
        ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b exp 0", ovf); end
        ebi_write(8'h16, 16'd6, 3);
        repeat (3) @(posedge clk);
        @(negedge clk); ovf_clr = 1'b1;
        @(posedge clk); #1;
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %0b exp 1", ovf); end
        @(negedge clk); ovf_clr = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", ovf); end
        wr_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (wr_valid !== 1'b1 || wr_data !== 16'(k) || wr_addr !== 8'h10 + 8'(k)) begin
                errors++; $display("FAIL ovf_drain%0d got v=%0b %0h/%0h exp v=1 %0h/%0h", k, wr_valid, wr_addr, wr_data, 8'h10 + 8'(k), k);
            end
            @(negedge clk);
        end
        wr_ready = 1'b0;
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL ovf_drained_level got %0d exp 0", fifo_level); end
    endtask

    task automatic test_full_pop();
        wr_ready = 1'b0;
        ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ebi_write(8'hA0 + 8'(i), 16'hA000 + 16'(i), 3);
            repeat (6) @(negedge clk);
        end
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fp_full got %0d exp 4", fifo_level); end
        ebi_write(8'hA4, 16'hA004, 3);
        repeat (3) @(posedge clk);
        @(negedge clk); wr_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fp_level got %0d exp 4", fifo_level); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fp_ovf got %0b exp 0", ovf); end
        @(negedge clk); wr_ready = 1'b0;
        wr_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (wr_valid !== 1'b1 || wr_data !== 16'hA000 + 16'(k) || wr_addr !== 8'hA0 + 8'(k)) begin
                errors++; $display("FAIL fp_drain%0d got v=%0b %0h/%0h exp v=1 %0h/%0h", k, wr_valid, wr_addr, wr_data, 8'hA0 + 8'(k), 16'hA000 + 16'(k));
            end
            @(negedge clk);
        end
        wr_ready = 1'b0;
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL fp_empty got %0b exp 0", wr_valid); end
    endtask

    task automatic test_ncs_rise();
        wr_ready = 1'b0;
        @(negedge clk);
        ebi_addr = 8'h77; ebi_data = 16'hCAFE; ebi_ncs = 1'b0; ebi_nwe = 1'b0;
        repeat (3) @(negedge clk);
        ebi_ncs = 1'b1; ebi_addr = 8'h00; ebi_data = 16'h0000;
        repeat (2) @(negedge clk);
        ebi_nwe = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL ncs_level got %0d exp 1", fifo_level); end
        checks++; if (wr_addr !== 8'h77) begin errors++; $display("FAIL ncs_addr got %0h exp 77", wr_addr); end
        checks++; if (wr_data !== 16'hCAFE) begin errors++; $display("FAIL ncs_data got %0h exp cafe", wr_data); end
        wr_ready = 1'b1;
        @(negedge clk); wr_ready = 1'b0;
    endtask

    task automatic test_reset_mid_strobe();
        wr_ready = 1'b0;
        ebi_write(8'h11, 16'h1111, 3);
        repeat (6) @(negedge clk);
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL rmid_pre_level got %0d exp 1", fifo_level); end
        @(negedge clk);
        ebi_addr = 8'h22; ebi_data = 16'h2222; ebi_ncs = 1'b0; ebi_nwe = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %0b exp 0", wr_valid); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rmid_level got %0d exp 0", fifo_level); end
        checks++; if (wr_addr !== 8'h00 || wr_data !== 16'h0000) begin errors++; $display("FAIL rmid_word got %0h/%0h exp 0/0", wr_addr, wr_data); end
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        ebi_nwe = 1'b1; ebi_ncs = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rmid_tail_level got %0d exp 0", fifo_level); end
        ebi_write(8'h33, 16'h1234, 3);
        repeat (6) @(negedge clk);
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL rmid_next_level got %0d exp 1", fifo_level); end
        checks++; if (wr_addr !== 8'h33 || wr_data !== 16'h1234) begin errors++; $display("FAIL rmid_next_word got %0h/%0h exp 33/1234", wr_addr, wr_data); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_min_width();
        test_glitch();
        test_overflow();
        test_full_pop();
        test_ncs_rise();
        test_reset_mid_strobe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
